uart_rx_frame_parser: RTL
=========================

# uart_rx_frame_parser

Byte-level receive framer sitting directly downstream of the UART receiver. It consumes the receiver's one-cycle `RxD_data_ready` strobe and `RxD_data` byte and assembles framed commands of the form SYNC, CMD, LEN, payload[LEN], CHK. Each frame's payload is buffered internally. A frame is presented to the command logic with a valid/ack handshake only when its checksum matches. Malformed, oversized or stalled frames are discarded, and each discard is flagged with an error code.

## Interface
- `SYNC_BYTE`, 8'hA5, frame start marker
- `MAX_LEN`, 16, maximum payload bytes (buffer depth); legal LEN is 0..MAX_LEN
- `ADDR_W`, 4, payload read address width; must satisfy 2^ADDR_W >= MAX_LEN
- `TIMEOUT_CYCLES`, 50000, maximum clk cycles allowed between bytes inside a frame (1 ms at 50 MHz)

- `clk`  in  1  system clock
- `rst`  in  1  reset: asynchronous, active-low
- `RxD_data_ready`  in  1  one-cycle strobe: `RxD_data` is valid
- `RxD_data`  in  8  received byte
- `frame_valid`  out  1  a complete, checksum-good frame is held in the buffer
- `frame_cmd`  out  8  CMD byte of the held frame
- `frame_len`  out  8  LEN of the held frame
- `frame_ack`  in  1  consumer has finished with the held frame
- `rd_addr`  in  ADDR_W  payload read index
- `rd_data`  out  8  payload byte at `rd_addr`, registered
- `frame_err`  out  1  one-cycle pulse when a frame is discarded
- `err_code`  out  2  01 = LEN > MAX_LEN, 10 = checksum mismatch, 11 = timeout; holds its value until the next error
- `drop_cnt`  out  8  saturating count of bytes discarded while a frame is held

## Operation
- States: IDLE, CMD, LEN, PAYLOAD, CHK, HOLD.
- IDLE
  - A byte equal to SYNC_BYTE moves to CMD.
  - Any other byte is discarded silently (not counted).
- CMD
  - Latches the byte into `frame_cmd` and seeds the running checksum with it.
  - Moves to LEN.
- LEN
  - Latches the byte into `frame_len` and XORs it into the checksum.
  - If LEN > MAX_LEN: pulse `frame_err`, set `err_code` = 01, go to IDLE.
  - If LEN == 0: go to CHK.
  - Otherwise: clear the payload index and go to PAYLOAD.
- PAYLOAD
  - Writes the byte to buffer[index], XORs it into the checksum, increments the index.
  - Moves to CHK after LEN bytes.
- CHK
  - On match with the running XOR of CMD, LEN and payload: go to HOLD.
  - On mismatch: pulse `frame_err`, set `err_code` = 10, go to IDLE.
- HOLD
  - `frame_valid` is 1; `frame_cmd`, `frame_len` and the buffer are frozen.
  - Every byte strobe increments `drop_cnt` (saturating at 255), including a strobe in the same cycle as `frame_ack`.
  - `frame_ack` returns to IDLE.
  - `frame_ack` outside HOLD is ignored.
- Inter-byte timer (CMD, LEN, PAYLOAD, CHK)
  - Cleared on entry to CMD and on every byte strobe; otherwise increments.
  - When it reaches TIMEOUT_CYCLES-1 with no strobe: pulse `frame_err`, set `err_code` = 11, go to IDLE.
  - A strobe in the expiry cycle wins: the byte is processed and the timer clears.
- A SYNC_BYTE value received mid-frame is ordinary data; there is no resynchronisation inside a frame.
- `rd_data` is registered from buffer[`rd_addr`] every cycle. An address >= `frame_len` returns stale buffer contents; this is not an error.

## Timing
- Reset values:
  - state IDLE
  - `frame_valid`, `frame_err`, `err_code`, `drop_cnt`, `frame_cmd`, `frame_len`, `rd_data` all 0
  - buffer contents are undefined
- Every byte is processed in the cycle its strobe is high. Back-to-back strobes on consecutive cycles must be handled.
- `frame_valid` rises on the cycle after the clock edge that samples the CHK strobe.
- `frame_err` is high for exactly one cycle: the cycle after the offending strobe, or after timer expiry.
- After an ack sampled at an edge, `frame_valid` is 0 from that edge on. A SYNC byte arriving in the cycle after that edge starts a new frame.
- `rd_data` latency is 1 cycle from `rd_addr`.
- Reset asserted mid-frame aborts immediately to IDLE with no `frame_err` pulse.

## Test plan
- Good frame: A5 10 02 11 22 21 → `frame_valid` = 1 one cycle after the 0x21 strobe; `frame_cmd` = 0x10, `frame_len` = 2; `rd_addr` 0 → `rd_data` 0x11, `rd_addr` 1 → 0x22 one cycle later; `frame_ack` → `frame_valid` 0.
- Bad checksum and zero length:
  - A5 10 02 11 22 20 → `frame_err` pulse with `err_code` = 10, `frame_valid` stays 0.
  - A5 07 00 07 → valid frame with `frame_len` = 0.
- Length and noise:
  - A5 01 11 → `err_code` = 01 immediately after the LEN byte.
  - Leading noise 00 FF 3C before a good frame → ignored, frame accepted, `drop_cnt` still 0.
- Timeout: A5 10, then no strobe for TIMEOUT_CYCLES → `frame_err` with `err_code` = 11. Repeat with a strobe exactly in the expiry cycle → no error, frame continues.
- Hold and drops: good frame held; send 300 bytes without ack → `drop_cnt` = 255, buffer and `frame_cmd` unchanged; strobe in the ack cycle is also counted.
- Back-to-back frames with one-cycle strobe spacing, ack issued between them → both frames delivered. Async reset pulsed mid-payload → all outputs return to 0, the next frame is parsed correctly.

Source files
------------

// File: rtl/uart_rx_frame_parser_if.sv
// Byte-stream and frame-handoff bundle between the UART receiver, the frame parser
// and the command logic that consumes buffered frames.
interface uart_rx_frame_parser_if #(
    parameter int ADDR_W = 4
);
    logic              RxD_data_ready;
    logic [7:0]        RxD_data;
    logic              frame_valid;
    logic [7:0]        frame_cmd;
    logic [7:0]        frame_len;
    logic              frame_ack;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_data;
    logic              frame_err;
    logic [1:0]        err_code;
    logic [7:0]        drop_cnt;

    modport slave (
        input  RxD_data_ready, RxD_data, frame_ack, rd_addr,
        output frame_valid, frame_cmd, frame_len, rd_data, frame_err, err_code, drop_cnt
    );

    modport master (
        output RxD_data_ready, RxD_data, frame_ack, rd_addr,
        input  frame_valid, frame_cmd, frame_len, rd_data, frame_err, err_code, drop_cnt
    );
endinterface

// File: rtl/uart_rx_frame_parser.sv
// Assembles SYNC/CMD/LEN/payload/CHK frames from received bytes, buffers the payload
// and hands checksum-good frames to the consumer; bad or stalled frames are flagged.
module uart_rx_frame_parser #(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         MAX_LEN        = 16,
    parameter int         ADDR_W         = 4,
    parameter int         TIMEOUT_CYCLES = 50000
) (
    input logic                   clk,
    input logic                   rst,
    uart_rx_frame_parser_if.slave bus
);
    localparam int             TMR_W     = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]     MAX_LEN_B = 8'(MAX_LEN);
    localparam int             DEPTH     = 2 ** ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CMD     = 3'd1,
        S_LEN     = 3'd2,
        S_PAYLOAD = 3'd3,
        S_CHK     = 3'd4,
        S_HOLD    = 3'd5
    } state_e;

    function automatic logic [7:0] chk_fold(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

    state_e            state_q, state_d;
    logic [7:0]        cmd_q, cmd_d;
    logic [7:0]        len_q, len_d;
    logic [7:0]        chk_q, chk_d;
    logic [7:0]        idx_q, idx_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic              err_q, err_d;
    logic [1:0]        code_q, code_d;
    logic [7:0]        drop_q, drop_d;
    logic              valid_q;
    logic [7:0]        rd_data_q;
    logic [7:0]        buf_q [DEPTH];
    logic              wr_en_s;
    logic              strb_s;
    logic [7:0]        data_s;
    logic              in_frame_s;
    logic              expire_s;

    assign strb_s     = bus.RxD_data_ready;
    assign data_s     = bus.RxD_data;
    assign in_frame_s = (state_q == S_CMD) || (state_q == S_LEN) ||
                        (state_q == S_PAYLOAD) || (state_q == S_CHK);
    assign expire_s   = in_frame_s && !strb_s && (tmr_q == TMR_LAST);

    // Next-state, datapath and error decode for the frame parser
    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        len_d   = len_q;
        chk_d   = chk_q;
        idx_d   = idx_q;
        tmr_d   = tmr_q;
        err_d   = 1'b0;
        code_d  = code_q;
        drop_d  = drop_q;
        wr_en_s = 1'b0;

        if (in_frame_s) begin
            tmr_d = strb_s ? {TMR_W{1'b0}} : (tmr_q + TMR_W'(1));
        end else begin
            tmr_d = tmr_q;
        end

        case (state_q)
            S_IDLE: begin
                if (strb_s && (data_s == SYNC_BYTE)) begin
                    state_d = S_CMD;
                    tmr_d   = {TMR_W{1'b0}};
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CMD: begin
                if (strb_s) begin
                    cmd_d   = data_s;
                    chk_d   = data_s;
                    state_d = S_LEN;
                end else begin
                    state_d = S_CMD;
                end
            end
            S_LEN: begin
                if (strb_s) begin
                    len_d = data_s;
                    chk_d = chk_fold(chk_q, data_s);
                    if (data_s > MAX_LEN_B) begin
                        err_d   = 1'b1;
                        code_d  = 2'b01;
                        state_d = S_IDLE;
                    end else if (data_s == 8'd0) begin
                        state_d = S_CHK;
                    end else begin
                        idx_d   = 8'd0;
                        state_d = S_PAYLOAD;
                    end
                end else begin
                    state_d = S_LEN;
                end
            end
            S_PAYLOAD: begin
                if (strb_s) begin
                    wr_en_s = 1'b1;
                    chk_d   = chk_fold(chk_q, data_s);
                    idx_d   = idx_q + 8'd1;
                    state_d = ((idx_q + 8'd1) == len_q) ? S_CHK : S_PAYLOAD;
                end else begin
                    state_d = S_PAYLOAD;
                end
            end
            S_CHK: begin
                if (strb_s) begin
                    if (data_s == chk_q) begin
                        state_d = S_HOLD;
                    end else begin
                        err_d   = 1'b1;
                        code_d  = 2'b10;
                        state_d = S_IDLE;
                    end
                end else begin
                    state_d = S_CHK;
                end
            end
            S_HOLD: begin
                // A byte arriving alongside the ack is still a dropped byte
                if (strb_s && (drop_q != 8'hFF)) begin
                    drop_d = drop_q + 8'd1;
                end else begin
                    drop_d = drop_q;
                end
                if (bus.frame_ack) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_HOLD;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (expire_s) begin
            err_d   = 1'b1;
            code_d  = 2'b11;
            state_d = S_IDLE;
        end else begin
            err_d = err_d;
        end
    end

    // Control and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cmd_q     <= 8'd0;
            len_q     <= 8'd0;
            chk_q     <= 8'd0;
            idx_q     <= 8'd0;
            tmr_q     <= {TMR_W{1'b0}};
            err_q     <= 1'b0;
            code_q    <= 2'b00;
            drop_q    <= 8'd0;
            valid_q   <= 1'b0;
            rd_data_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            len_q     <= len_d;
            chk_q     <= chk_d;
            idx_q     <= idx_d;
            tmr_q     <= tmr_d;
            err_q     <= err_d;
            code_q    <= code_d;
            drop_q    <= drop_d;
            valid_q   <= (state_d == S_HOLD);
            rd_data_q <= buf_q[bus.rd_addr];
        end
    end

    // Payload storage; contents are not reset
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            buf_q[idx_q[ADDR_W-1:0]] <= data_s;
        end
    end

    assign bus.frame_valid = valid_q;
    assign bus.frame_cmd   = cmd_q;
    assign bus.frame_len   = len_q;
    assign bus.rd_data     = rd_data_q;
    assign bus.frame_err   = err_q;
    assign bus.err_code    = code_q;
    assign bus.drop_cnt    = drop_q;
endmodule
